cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit CPU. Steps each instruction through fetch, decode, execute, optional memory access and writeback. Arbitrates the single shared memory port between instruction fetch and ld/st data access. Gates the opcode decoder's static control signals into per-phase write strobes.

Parameters:
WAIT_MAX, 15, max cycles any memory wait state may last before fault; 0 disables the timeout
CNT_W, 16, width of the performance counters (SEQ_PERF_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = execute; 0 = halt at the next instruction boundary
opcode  in  5  opcode field of the instruction register
dec_reg_write  in  1  decoder RegWrite
dec_mem_write  in  1  decoder MemWrite
dec_nz  in  1  decoder NZ-update request
dec_pc_enable  in  1  decoder pc_enable
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_sel  out  1  0 = instruction fetch, 1 = data access
mem_we  out  1  data write strobe
ir_load  out  1  latch fetched word into IR
pc_load  out  1  update PC
rf_we  out  1  register-file write strobe
nz_load  out  1  NZ flag update strobe
busy  out  1  1 = not in S_IDLE or S_FAULT
fault  out  1  sticky memory-timeout flag
state  out  3  current state encoding, for debug

Behaviour:
- Encoding: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_FAULT=6.
- Reset: the state goes to S_IDLE and the wait counter clears. All outputs are 0 and fault clears. Reset has priority over every other input, including mid-access; mem_req is 0 in the cycle after reset is sampled.
- S_IDLE: all strobes are 0. If run=1, go to S_FETCH; otherwise stay.
- S_FETCH: mem_req=1, mem_sel=0.
  - If mem_ready=1, ir_load=1 in that same cycle and the next state is S_DECODE.
  - Otherwise stay and increment the wait counter.
- S_DECODE: no strobes. Next state is S_EXEC.
- S_EXEC: no strobes.
  - opcode 00100 (ld) or 00101 (st): next state is S_MEM.
  - Any other opcode: next state is S_WB.
- S_MEM: mem_req=1, mem_sel=1, mem_we=(opcode==00101)&dec_mem_write, held stable until mem_ready=1. Then next state is S_WB; otherwise stay and count.
- S_WB: single cycle, with these strobes:
  - rf_we=dec_reg_write
  - nz_load=dec_nz
  - pc_load=dec_pc_enable
  - Next state is S_FETCH if run=1, else S_IDLE.
- Handshake:
  - mem_ready is ignored whenever mem_req=0.
  - mem_sel and mem_we must not change while mem_req=1 and mem_ready=0.
  - Each access completes on exactly one mem_ready cycle.
- Wait counter: clears on entry to every state.
  - In S_FETCH or S_MEM with WAIT_MAX>0, if the counter reaches WAIT_MAX with mem_ready=0, go to S_FAULT.
  - If mem_ready=1 arrives in the same cycle the limit is reached, the access completes and no fault is raised.
- S_FAULT: fault=1, all strobes 0. Only reset leaves this state.
- Timing: a non-memory instruction with zero-wait memory takes 4 cycles (FETCH, DECODE, EXEC, WB). ld/st takes 5 cycles plus memory waits.
- run=0 mid-instruction: the current instruction completes through S_WB, then the sequencer enters S_IDLE.
- Strobe exclusivity: at most one of ir_load, rf_we, mem_we is 1 in any cycle.
- Unknown or unimplemented opcodes follow the non-memory path, with strobes taken from decoder outputs.

Optional Feature:
- Macro SEQ_PERF_EN.
- When defined, add two outputs:
  - instr_cnt (CNT_W): increments on every S_WB cycle.
  - stall_cnt (CNT_W): increments on every S_FETCH/S_MEM cycle with mem_req=1 and mem_ready=0.
- Both counters clear on reset, wrap modulo 2^CNT_W, and hold in S_IDLE/S_FAULT.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
1. reset, run=1, opcode=00001, dec_reg_write=1, mem_ready tied 1 -> ir_load in cycle 1, rf_we and pc_load in cycle 4 only, repeating every 4 cycles.
2. opcode=00101 st, dec_mem_write=1, mem_ready low 3 cycles in S_MEM -> mem_req=1, mem_sel=1, mem_we=1 held stable 4 cycles; S_WB follows; instruction takes 8 cycles total.
3. WAIT_MAX=15, mem_ready held 0 in S_FETCH -> S_FAULT after 15 wait cycles, fault=1 and all strobes 0 until reset; repeat with mem_ready=1 on the limit cycle -> no fault.
4. run dropped during S_EXEC of an addi (dec_nz=1) -> nz_load and rf_we pulse in S_WB, then S_IDLE with busy=0; run=1 resumes in S_FETCH.
5. reset asserted in S_MEM with mem_req=1 -> next cycle state=0, all outputs 0, fault=0.
6. SEQ_PERF_EN, CNT_W=4, run 17 zero-wait instructions -> instr_cnt=1 (wrapped), stall_cnt=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with shared memory port arbitration
// Optional performance counters are enabled by defining SEQ_PERF_EN.
module cpu_sequencer #(
  parameter int WAIT_MAX = 15
`ifdef SEQ_PERF_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_nz,
  input  logic             dec_pc_enable,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_load,
  output logic             rf_we,
  output logic             nz_load,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state
`ifdef SEQ_PERF_EN
  , output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam int             WCW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);
  localparam logic [4:0]     OP_LD    = 5'b00100;
  localparam logic [4:0]     OP_ST    = 5'b00101;

  state_t         cur_state;
  state_t         nxt_state;
  logic [WCW-1:0] wait_cnt;
  logic           we_q;
  logic           timeout;
  logic           mem_phase;

  assign mem_phase = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign timeout   = (WAIT_MAX > 0) && (wait_cnt == WAIT_LIM);

  // The write strobe is captured on leaving EXEC so it cannot move during a wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (mem_phase && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (cur_state == S_EXEC)
        we_q <= (opcode == OP_ST) && dec_mem_write;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    rf_we     = 1'b0;
    nz_load   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run)
          nxt_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout) begin
          nxt_state = S_FAULT;
        end
      end
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LD || opcode == OP_ST)
          nxt_state = S_MEM;
        else
          nxt_state = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = we_q;
        if (mem_ready)
          nxt_state = S_WB;
        else if (timeout)
          nxt_state = S_FAULT;
      end
      S_WB: begin
        rf_we     = dec_reg_write;
        nz_load   = dec_nz;
        pc_load   = dec_pc_enable;
        nxt_state = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: nxt_state = S_FAULT;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign busy  = (cur_state != S_IDLE) && (cur_state != S_FAULT);
  assign fault = (cur_state == S_FAULT);
  assign state = cur_state;

`ifdef SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (cur_state == S_WB)
        instr_cnt <= instr_cnt + 1'b1;
      if (mem_phase && !mem_ready)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer against a per-instruction trace model
module tb_cpu_sequencer;

  localparam int TB_CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [4:0] opcode = '0;
  logic       dec_reg_write = 1'b0;
  logic       dec_mem_write = 1'b0;
  logic       dec_nz = 1'b0;
  logic       dec_pc_enable = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_sel, mem_we, ir_load, pc_load, rf_we, nz_load, busy, fault;
  logic [2:0] state;
`ifdef SEQ_PERF_EN
  logic [TB_CNT_W-1:0] instr_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int instr_m = 0;
  int stall_m = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .WAIT_MAX(15)
`ifdef SEQ_PERF_EN
    , .CNT_W(TB_CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_nz(dec_nz), .dec_pc_enable(dec_pc_enable), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load),
    .pc_load(pc_load), .rf_we(rf_we), .nz_load(nz_load), .busy(busy),
    .fault(fault), .state(state)
`ifdef SEQ_PERF_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  wire [11:0] obs = {state, mem_req, mem_sel, mem_we, ir_load, pc_load, rf_we, nz_load, busy, fault};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vector for a phase: busy/fault follow from the phase alone.
  function automatic logic [11:0] ev(input logic [2:0] st, input logic req, input logic sel,
                                     input logic we, input logic ir, input logic pc,
                                     input logic rf, input logic nz);
    logic b, f;
    f = (st == 3'd6);
    b = (st != 3'd0) && !f;
    return {st, req, sel, we, ir, pc, rf, nz, b, f};
  endfunction

  task automatic cyc(input logic rdy, input logic rn, input logic [11:0] exp, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    run = rn;
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    if (exp[11:9] == 3'd5) instr_m++;
    if ((exp[11:9] == 3'd1 || exp[11:9] == 3'd4) && !rdy) stall_m++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    instr_m = 0;
    stall_m = 0;
  endtask

  // One instruction from its first FETCH cycle through WB.
  task automatic instr(input logic [4:0] op, input logic rw, input logic mw, input logic nz,
                       input logic pe, input int fw, input int mwait, input logic run_next,
                       input logic drop);
    logic is_mem, we;
    opcode = op;
    dec_reg_write = rw;
    dec_mem_write = mw;
    dec_nz = nz;
    dec_pc_enable = pe;
    is_mem = (op == 5'b00100) || (op == 5'b00101);
    we = (op == 5'b00101) && mw;
    for (int i = 0; i < fw; i++) cyc(1'b0, rb(), ev(3'd1, 1, 0, 0, 0, 0, 0, 0), "fetch_wait");
    cyc(1'b1, rb(), ev(3'd1, 1, 0, 0, 1, 0, 0, 0), "fetch_done");
    cyc(rb(), rb(), ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "decode");
    cyc(rb(), drop ? 1'b0 : rb(), ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "exec");
    if (is_mem) begin
      for (int i = 0; i < mwait; i++)
        cyc(1'b0, drop ? 1'b0 : rb(), ev(3'd4, 1, 1, we, 0, 0, 0, 0), "mem_wait");
      cyc(1'b1, drop ? 1'b0 : rb(), ev(3'd4, 1, 1, we, 0, 0, 0, 0), "mem_done");
    end
    cyc(rb(), drop ? 1'b0 : run_next, ev(3'd5, 0, 0, 0, 0, pe, rw, nz), "writeback");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(rb(), 1'b0, ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "idle");
    cyc(rb(), 1'b1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "idle_start");
  endtask

  task automatic check_perf(input string tag);
`ifdef SEQ_PERF_EN
    logic [TB_CNT_W-1:0] ei, es;
    ei = TB_CNT_W'(instr_m);
    es = TB_CNT_W'(stall_m);
    checks++;
    assert (instr_cnt === ei) else begin
      errors++;
      $error("FAIL %s_instr observed=%0d expected=%0d", tag, instr_cnt, ei);
    end
    checks++;
    assert (stall_cnt === es) else begin
      errors++;
      $error("FAIL %s_stall observed=%0d expected=%0d", tag, stall_cnt, es);
    end
`else
    if (tag.len() == 0) $display("%s", tag);
`endif
  endtask

  initial begin
    logic [4:0] op;
    logic rn;
    int fw, mwt;

    // Reset state
    do_reset();
    #1;
    checks++;
    assert (obs === ev(3'd0, 0, 0, 0, 0, 0, 0, 0)) else begin
      errors++;
      $error("FAIL reset_state observed=%h expected=%h", obs, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    end
    check_perf("reset");

    // Back-to-back zero-wait ALU instructions: 4 cycles each
    idle(0);
    for (int k = 0; k < 3; k++) instr(5'b00001, 1, 0, 0, 1, 0, 0, 1'b1, 1'b0);
    // Store with three wait cycles in MEM
    instr(5'b00101, 0, 1, 0, 1, 0, 3, 1'b1, 1'b0);
    // Load at the wait limit in both phases completes without fault
    instr(5'b00100, 1, 1, 0, 1, 15, 15, 1'b1, 1'b0);
    // run dropped in EXEC of an addi: finish WB, park in IDLE, then resume
    instr(5'b00010, 1, 0, 1, 1, 0, 0, 1'b0, 1'b1);
    idle(3);
    instr(5'b00011, 0, 0, 1, 1, 1, 0, 1'b1, 1'b0);
    check_perf("directed");

    // Randomized program, including unknown opcodes
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: op = 5'b00100;
        1: op = 5'b00101;
        default: op = 5'($urandom_range(0, 31));
      endcase
      fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      mwt = $urandom_range(0, 4);
      rn = ($urandom_range(0, 4) != 0);
      instr(op, rb(), rb(), rb(), rb(), fw, mwt, rn, 1'b0);
      if (!rn) idle($urandom_range(0, 2));
    end
    check_perf("random");

    // Fetch timeout: 15 wait cycles, then the limit cycle faults
    do_reset();
    idle(0);
    for (int i = 0; i < 15; i++) cyc(1'b0, rb(), ev(3'd1, 1, 0, 0, 0, 0, 0, 0), "to_wait");
    cyc(1'b0, 1'b1, ev(3'd1, 1, 0, 0, 0, 0, 0, 0), "to_limit");
    for (int i = 0; i < 4; i++) begin
      opcode = 5'($urandom_range(0, 31));
      dec_reg_write = 1'b1;
      dec_pc_enable = 1'b1;
      cyc(rb(), rb(), ev(3'd6, 0, 0, 0, 0, 0, 0, 0), "fault_hold");
    end
    check_perf("fault");

    // Reset in the middle of a data access
    do_reset();
    idle(0);
    opcode = 5'b00100;
    cyc(1'b1, 1'b1, ev(3'd1, 1, 0, 0, 1, 0, 0, 0), "rst_fetch");
    cyc(1'b0, 1'b1, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "rst_decode");
    cyc(1'b0, 1'b1, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "rst_exec");
    cyc(1'b0, 1'b1, ev(3'd4, 1, 1, 0, 0, 0, 0, 0), "rst_mem");
    do_reset();
    #1;
    checks++;
    assert (obs === ev(3'd0, 0, 0, 0, 0, 0, 0, 0)) else begin
      errors++;
      $error("FAIL reset_mid_mem observed=%h expected=%h", obs, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    end

    // 17 zero-wait instructions wrap a 4-bit instruction counter to 1
    idle(0);
    for (int k = 0; k < 17; k++) instr(5'b00001, 1, 0, 0, 1, 0, 0, k != 16, 1'b0);
    cyc(rb(), 1'b0, ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "wrap_idle");
    check_perf("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
